// File: rtl/svc_soc_uart_rx_reg.sv
// UART 8N1 receiver with a receive FIFO and data/status registers on the SOC I/O bus.
// State table:
//   S_IDLE  | line idle high, waiting for a synchronized falling edge
//   S_START | counting to the start-bit centre, rejecting glitches
//   S_DATA  | sampling 8 data bits at bit centres, LSB first
//   S_STOP  | sampling the stop bit; high pushes the byte, low flags ferr
//   S_BREAK | line held low after a framing error, waiting for high
module svc_soc_uart_rx_reg #(
  parameter int          CLOCK_FREQ = 100_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        urx_pin,
  output logic        rx_irq
);

  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]   ADDR_DATA   = BASE_ADDR;
  localparam logic [31:0]   ADDR_STATUS = BASE_ADDR + 32'd4;

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("svc_soc_uart_rx_reg: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 128 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("svc_soc_uart_rx_reg: FIFO_DEPTH must be a power of two in 2..128");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_push_req;
  logic          w_ferr_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   w_count;
  logic [7:0]    w_count8;
  logic          w_empty;
  logic          w_full;
  logic [7:0]    w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;

  logic          r_ovf;
  logic          r_ferr;
  logic          w_wr_data;
  logic          w_wr_status;
  logic [31:0]   w_rdata_nxt;
  logic          w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= urx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Every path into S_IDLE leaves the line high, so a low level seen in IDLE is the falling edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!w_rx) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_BIT;
            w_bit_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = CNT_BIT;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (w_rx) begin
            w_push_req  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_BREAK: begin
        if (w_rx) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_wr_data   = io_wen && io_wstrb[0] && (io_waddr == ADDR_DATA);
  assign w_wr_status = io_wen && io_wstrb[0] && (io_waddr == ADDR_STATUS);

  assign w_count   = r_wptr - r_rptr;
  assign w_count8  = 8'(w_count);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (w_count == DEPTH_V);
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_pop     = w_wr_data && !w_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovf_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && io_wdata[2]) begin
        r_ovf <= 1'b0;
      end
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (w_wr_status && io_wdata[3]) begin
        r_ferr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    if (io_ren) begin
      if (io_raddr == ADDR_DATA) begin
        w_rdata_nxt = {23'd0, !w_empty, (w_empty ? 8'd0 : w_head)};
      end else if (io_raddr == ADDR_STATUS) begin
        w_rdata_nxt = {16'd0, w_count8, 4'd0, r_ferr, r_ovf, w_full, !w_empty};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
    end else begin
      io_rdata <= w_rdata_nxt;
    end
  end

  assign rx_irq = !w_empty;

  assign w_unused = &{1'b0, io_wstrb[3:1], io_wdata[31:4], io_wdata[1:0]};

endmodule

// File: tb/tb_svc_soc_uart_rx_reg.sv
// Directed bench for svc_soc_uart_rx_reg; baud rate raised so CPB = 16 and the run stays short.
module tb_svc_soc_uart_rx_reg;

  localparam int          CLK_FREQ = 100_000_000;
  localparam int          BAUD     = 6_250_000;
  localparam int          CPB      = CLK_FREQ / BAUD;
  localparam int          H        = CPB / 2;
  localparam int          PUSH_OFS = 2 + H + 9 * CPB;
  localparam logic [31:0] A_DATA   = 32'h8000_0100;
  localparam logic [31:0] A_STAT   = 32'h8000_0104;

  logic        clk;
  logic        rst_n;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        urx_pin;
  logic        rx_irq;

  int errors = 0;
  int checks = 0;

  svc_soc_uart_rx_reg #(
    .CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(16),
    .BASE_ADDR (A_DATA)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_ren  (io_ren),
    .io_raddr(io_raddr),
    .io_rdata(io_rdata),
    .io_wen  (io_wen),
    .io_waddr(io_waddr),
    .io_wdata(io_wdata),
    .io_wstrb(io_wstrb),
    .urx_pin (urx_pin),
    .rx_irq  (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling clock edge.
  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    io_ren   = 1'b1;
    io_raddr = addr;
    @(negedge clk);
    io_ren   = 1'b0;
    io_raddr = '0;
    check(tag, io_rdata, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    io_wen   = 1'b1;
    io_waddr = addr;
    io_wdata = data;
    io_wstrb = 4'h1;
    @(negedge clk);
    io_wen   = 1'b0;
    io_wstrb = 4'h0;
    io_waddr = '0;
    io_wdata = '0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_cycles);
    urx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      urx_pin = d[i];
      repeat (CPB) @(negedge clk);
    end
    urx_pin = stop_lvl;
    repeat (stop_cycles) @(negedge clk);
    urx_pin = 1'b1;
  endtask

  // Pop issued so that its write lands on the stop-bit sample edge of a frame started now.
  task automatic pop_on_push();
    repeat (PUSH_OFS) @(posedge clk);
    @(negedge clk);
    wr(A_DATA, 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    io_ren   = 1'b0;
    io_raddr = '0;
    io_wen   = 1'b0;
    io_waddr = '0;
    io_wdata = '0;
    io_wstrb = '0;
    urx_pin  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_irq", {31'd0, rx_irq}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk("reset_status", A_STAT, 32'h0);
    rd_chk("reset_data", A_DATA, 32'h0);

    // 1: single frame, push timing and read/write basics
    fork
      send_frame(8'hA5, 1'b1, CPB);
      begin
        repeat (PUSH_OFS) @(posedge clk);
        @(negedge clk);
        check("t1_irq_before_push", {31'd0, rx_irq}, 32'h0);
        @(negedge clk);
        check("t1_irq_after_push", {31'd0, rx_irq}, 32'h1);
      end
    join
    rd_chk("t1_status", A_STAT, 32'h0000_0101);
    rd_chk("t1_data", A_DATA, 32'h0000_01A5);
    rd_chk("t1_data_again", A_DATA, 32'h0000_01A5);
    rd_chk("t1_unmapped", A_DATA + 32'd8, 32'h0);
    io_raddr = A_DATA;
    @(negedge clk);
    check("t1_ren_low", io_rdata, 32'h0);
    io_ren   = 1'b1;
    io_raddr = A_DATA;
    wr(A_DATA, 32'h0);
    io_ren = 1'b0;
    check("t1_read_during_pop", io_rdata, 32'h0000_01A5);
    check("t1_irq_after_pop", {31'd0, rx_irq}, 32'h0);
    rd_chk("t1_status_empty", A_STAT, 32'h0);

    // 2: overflow with 17 frames
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, CPB);
    repeat (4) @(negedge clk);
    rd_chk("t2_status_full", A_STAT, 32'h0000_1007);
    rd_chk("t2_data_head", A_DATA, 32'h0000_0100);
    for (int i = 0; i < 16; i++) begin
      rd_chk("t2_pop_order", A_DATA, 32'h100 | 32'(i));
      wr(A_DATA, 32'hFFFF_FFFF);
    end
    rd_chk("t2_data_empty", A_DATA, 32'h0);
    rd_chk("t2_status_ovf", A_STAT, 32'h0000_0004);
    wr(A_STAT, 32'h4);
    rd_chk("t2_ovf_clear", A_STAT, 32'h0);

    // 3: framing error, then recovery
    send_frame(8'h3C, 1'b0, 2 * CPB);
    repeat (4) @(negedge clk);
    rd_chk("t3_ferr", A_STAT, 32'h0000_0008);
    send_frame(8'h55, 1'b1, CPB);
    repeat (4) @(negedge clk);
    rd_chk("t3_status_after", A_STAT, 32'h0000_0109);
    rd_chk("t3_data", A_DATA, 32'h0000_0155);
    wr(A_STAT, 32'h8);
    rd_chk("t3_ferr_clear", A_STAT, 32'h0000_0101);
    wr(A_DATA, 32'h0);

    // 4: short low pulse is rejected
    urx_pin = 1'b0;
    repeat (H - 4) @(negedge clk);
    urx_pin = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rd_chk("t4_glitch_status", A_STAT, 32'h0);
    send_frame(8'h81, 1'b1, CPB);
    repeat (4) @(negedge clk);
    rd_chk("t4_data", A_DATA, 32'h0000_0181);
    wr(A_DATA, 32'h0);

    // 5: pop on the push cycle, with one entry and with a full FIFO
    send_frame(8'h11, 1'b1, CPB);
    fork
      send_frame(8'h7E, 1'b1, CPB);
      pop_on_push();
    join
    repeat (4) @(negedge clk);
    rd_chk("t5_status_one", A_STAT, 32'h0000_0101);
    rd_chk("t5_head_7e", A_DATA, 32'h0000_017E);
    for (int i = 0; i < 15; i++) send_frame(8'h20 + 8'(i), 1'b1, CPB);
    repeat (4) @(negedge clk);
    rd_chk("t5_status_full", A_STAT, 32'h0000_1003);
    fork
      send_frame(8'h99, 1'b1, CPB);
      pop_on_push();
    join
    repeat (4) @(negedge clk);
    rd_chk("t5_full_no_ovf", A_STAT, 32'h0000_1003);
    for (int i = 0; i < 15; i++) begin
      rd_chk("t5_drain", A_DATA, 32'h120 + 32'(i));
      wr(A_DATA, 32'h0);
    end
    rd_chk("t5_last", A_DATA, 32'h0000_0199);
    wr(A_DATA, 32'h0);
    rd_chk("t5_empty", A_STAT, 32'h0);

    // 6: reset during data bit 4
    fork
      send_frame(8'hFF, 1'b1, CPB);
      begin
        repeat (5 * CPB + H) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    rd_chk("t6_status_after_rst", A_STAT, 32'h0);
    check("t6_irq", {31'd0, rx_irq}, 32'h0);
    send_frame(8'h12, 1'b1, CPB);
    repeat (4) @(negedge clk);
    rd_chk("t6_data", A_DATA, 32'h0000_0112);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
